video_clken_synth: RTL and testbench

- Multi-channel digital clock-enable synthesiser. Each channel is a phase-accumulator NCO.
- Produces single-cycle enable pulses at a programmable fraction of refclk (e.g. 25.175644 MHz pixel enable from 50 MHz) for video and peripheral logic.
- Each channel has a PLL-style settle/lock indication. Channels are reprogrammed at runtime through a valid/ready config port without a new clock domain.

---
 rtl/video_clken_synth.sv | 158 +++++++++++++++
 tb/tb_video_clken_synth.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_clken_synth.sv
// Multi-channel NCO clock-enable synthesiser: per-channel phase accumulators emit
// single-cycle refclk enables, with a settle/lock flag and a 2-stage config port.

module video_clken_ch #(
  parameter int               ACC_W       = 32,
  parameter int               LOCK_CYCLES = 1024,
  parameter logic [ACC_W-1:0] INC_DEFAULT = '0
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             commit_i,
  input  logic [ACC_W-1:0] commit_inc_i,
  output logic             clken_o,
  output logic             locked_o,
  output logic             en_o
);
  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  localparam int               CNT_W     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LOCK_CYCLES - 1);
  // Reset is itself a (re)start: release cycle counts as the first SETTLE cycle.
  localparam state_t           RST_STATE = (INC_DEFAULT != '0) ? SETTLE : IDLE;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic             clken_q, clken_d;
  logic [ACC_W:0]   sum;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      acc_q   <= '0;
      inc_q   <= INC_DEFAULT;
      clken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      clken_q <= clken_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    inc_d   = inc_q;
    clken_d = 1'b0;
    sum     = {1'b0, acc_q} + {1'b0, inc_q};
    case (state_q)
      IDLE:   acc_d = '0;
      SETTLE: begin
        acc_d = sum[ACC_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = LOCKED;
      end
      LOCKED: begin
        acc_d   = sum[ACC_W-1:0];
        clken_d = sum[ACC_W];
      end
      default: state_d = IDLE;
    endcase
    // A commit overrides any carry landing on the same edge.
    if (commit_i) begin
      inc_d   = commit_inc_i;
      acc_d   = '0;
      cnt_d   = '0;
      clken_d = 1'b0;
      state_d = (commit_inc_i != '0) ? SETTLE : IDLE;
    end
  end

  assign clken_o  = clken_q;
  assign locked_o = (state_q == LOCKED);
  assign en_o     = (inc_q != '0);
endmodule

module video_clken_synth #(
  parameter int               NUM_CH      = 2,
  parameter int               ACC_W       = 32,
  parameter int               LOCK_CYCLES = 1024,
  parameter logic [ACC_W-1:0] INC_DEFAULT = ACC_W'(32'd2162571353),
  localparam int              CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clken,
  output logic [NUM_CH-1:0] locked,
  output logic              locked_all
);
  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [ACC_W-1:0] inc;
  } cfg_req_t;

  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  logic        rdy_q, rdy_d;
  logic        pend_vld_q, pend_vld_d;
  logic        err_q, err_d;
  cfg_req_t    pend_q, pend_d;
  logic        accept, ch_ok;
  logic [NUM_CH-1:0] en;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
      pend_q     <= '0;
    end else begin
      rdy_q      <= rdy_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
      pend_q     <= pend_d;
    end
  end

  // Accept stage: an accepted request drops ready for exactly the commit cycle.
  always_comb begin
    accept     = cfg_valid & rdy_q;
    ch_ok      = ({1'b0, cfg_ch} < NUM_CH_L);
    rdy_d      = ~accept;
    pend_vld_d = accept & ch_ok;
    err_d      = accept & ~ch_ok;
    pend_d     = pend_q;
    if (accept) pend_d = '{ch: cfg_ch, inc: cfg_inc};
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    video_clken_ch #(
      .ACC_W      (ACC_W),
      .LOCK_CYCLES(LOCK_CYCLES),
      .INC_DEFAULT(INC_DEFAULT)
    ) u_ch (
      .refclk      (refclk),
      .rst_n       (rst_n),
      .commit_i    (pend_vld_q && (pend_q.ch == CH_W'(i))),
      .commit_inc_i(pend_q.inc),
      .clken_o     (clken[i]),
      .locked_o    (locked[i]),
      .en_o        (en[i])
    );
  end

  assign cfg_ready  = rdy_q;
  assign cfg_err    = err_q;
  assign locked_all = (|en) & (&(locked | ~en));
endmodule

// File: tb/tb_video_clken_synth.sv
// Randomised bench: closed-form reference (pulse/lock timing from entry cycle and increment)
// for a 2-channel DUT plus a 3-channel DUT used to reach the invalid-channel path.

module tb_video_clken_synth;
  localparam int NCH  = 2;
  localparam int AW   = 8;
  localparam int LOCK = 16;
  localparam int INCD = 64;

  logic refclk = 1'b0;
  logic rst_n  = 1'b0;
  logic cfg_valid = 1'b0, cfg_valid3 = 1'b0;
  logic [0:0]    cfg_ch  = '0;
  logic [1:0]    cfg_ch3 = 2'd3;
  logic [AW-1:0] cfg_inc = '0;
  logic cfg_ready, cfg_err, locked_all;
  logic [NCH-1:0] clken, locked;
  logic cfg_ready3, cfg_err3, locked_all3;
  logic [2:0] clken3, locked3;

  always #5 refclk = ~refclk;

  video_clken_synth #(.NUM_CH(NCH), .ACC_W(AW), .LOCK_CYCLES(LOCK), .INC_DEFAULT(8'd64)) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_err(cfg_err), .clken(clken),
    .locked(locked), .locked_all(locked_all));

  video_clken_synth #(.NUM_CH(3), .ACC_W(AW), .LOCK_CYCLES(LOCK), .INC_DEFAULT(8'd64)) dut3 (
    .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
    .cfg_ch(cfg_ch3), .cfg_inc(cfg_inc), .cfg_err(cfg_err3), .clken(clken3),
    .locked(locked3), .locked_all(locked_all3));

  int n_vec = 0, n_err = 0;

  // Reference state: cycle index since reset release, per-channel entry cycle and increment.
  longint c;
  longint t_m[NCH];
  longint inc_m[NCH];
  bit     rdy_m, pend_m, rdy3_m, err3_m;
  int     pch;
  longint pinc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, c);
    end
  endtask

  function automatic bit exp_lk(longint inc, longint t, longint cc);
    return (inc != 0) && (cc - t >= LOCK);
  endfunction

  // Pulse visible in cycle cc iff the channel was locked in cc-1 and acc crossed 2^AW on edge cc.
  function automatic bit exp_ck(longint inc, longint t, longint cc);
    longint n = cc - t;
    if (inc == 0 || n - 1 < LOCK) return 1'b0;
    return ((inc * n) >> AW) != ((inc * (n - 1)) >> AW);
  endfunction

  task automatic model_reset();
    c = 0;
    for (int i = 0; i < NCH; i++) begin t_m[i] = 0; inc_m[i] = INCD; end
    rdy_m = 0; pend_m = 0; rdy3_m = 0; err3_m = 0;
  endtask

  task automatic model_edge();
    bit acc, acc3;
    c++;
    if (pend_m) begin inc_m[pch] = pinc; t_m[pch] = c; end
    acc    = cfg_valid && rdy_m;
    pend_m = acc;
    pch    = int'(cfg_ch);
    pinc   = longint'(cfg_inc);
    rdy_m  = !acc;
    acc3   = cfg_valid3 && rdy3_m;
    err3_m = acc3 && (cfg_ch3 >= 2'd3);
    rdy3_m = !acc3;
  endtask

  task automatic compare();
    logic [NCH-1:0] elk, eck;
    logic [2:0] elk3, eck3;
    bit any_en, all_lk;
    any_en = 0; all_lk = 1;
    for (int i = 0; i < NCH; i++) begin
      elk[i] = exp_lk(inc_m[i], t_m[i], c);
      eck[i] = exp_ck(inc_m[i], t_m[i], c);
      if (inc_m[i] != 0) begin any_en = 1; if (!elk[i]) all_lk = 0; end
    end
    for (int i = 0; i < 3; i++) begin
      elk3[i] = exp_lk(INCD, 0, c);
      eck3[i] = exp_ck(INCD, 0, c);
    end
    chk("cfg_ready", 32'(cfg_ready), 32'(rdy_m));
    chk("cfg_err", 32'(cfg_err), 32'd0);
    chk("locked", 32'(locked), 32'(elk));
    chk("clken", 32'(clken), 32'(eck));
    chk("locked_all", 32'(locked_all), 32'(any_en && all_lk));
    chk("cfg_ready3", 32'(cfg_ready3), 32'(rdy3_m));
    chk("cfg_err3", 32'(cfg_err3), 32'(err3_m));
    chk("locked3", 32'(locked3), 32'(elk3));
    chk("clken3", 32'(clken3), 32'(eck3));
  endtask

  task automatic tick();
    @(posedge refclk);
    model_edge();
    @(negedge refclk);
    compare();
  endtask

  task automatic wait_rdy();
    int w = 0;
    while (!rdy_m && w < 8) begin tick(); w++; end
    if (!rdy_m) chk("ready_wait", 32'(cfg_ready), 32'd1);
  endtask

  task automatic send(input int ch, input int inc);
    wait_rdy();
    cfg_valid = 1'b1; cfg_ch = 1'(ch); cfg_inc = AW'(inc);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_clken"}, 32'(clken), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd0);
    chk({tag, "_lall"}, 32'(locked_all), 32'd0);
    chk({tag, "_err3"}, 32'(cfg_err3), 32'd0);
    chk({tag, "_ready3"}, 32'(cfg_ready3), 32'd0);
  endtask

  initial begin
    bit found;
    int inc0;
    model_reset();
    #12;
    chk_all_reset("rst");

    // Free-run from reset at the default increment.
    @(negedge refclk);
    rst_n = 1'b1;
    model_reset();
    repeat (60) tick();

    // Reconfigure ch1 to a 3-per-8 rate while locked.
    send(1, 96);
    repeat (60) tick();

    // Disable ch0, then near-full rate.
    send(0, 0);
    repeat (40) tick();
    send(0, 255);
    repeat (300) tick();

    // Invalid channel on the 3-channel instance, single then back-to-back.
    wait_rdy();
    cfg_valid3 = 1'b1; tick(); cfg_valid3 = 1'b0;
    repeat (4) tick();
    cfg_valid3 = 1'b1; repeat (6) tick(); cfg_valid3 = 1'b0;
    repeat (4) tick();

    // Back-to-back requests with cfg_valid held high.
    send(0, 64);
    cfg_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cfg_ch  = 1'($urandom_range(0, 1));
      cfg_inc = AW'($urandom_range(0, 255));
      tick();
    end
    cfg_valid = 1'b0;
    repeat (40) tick();

    // Land a commit on ch0 exactly on an edge that would carry; identical increment.
    inc0 = $urandom_range(32, 200);
    send(0, inc0);
    repeat (24) tick();
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (rdy_m && exp_ck(inc_m[0], t_m[0], c + 2)) begin
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = AW'(inc0);
        tick();
        cfg_valid = 1'b0;
        tick();
        chk("commit_vs_carry", 32'(clken[0]), 32'd0);
        found = 1;
      end else tick();
    end
    repeat (30) tick();

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch    = 1'($urandom_range(0, 1));
        cfg_inc   = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, 255));
      end else cfg_valid = 1'b0;
      tick();
    end
    cfg_valid = 1'b0;
    repeat (40) tick();

    // Reset mid-SETTLE of ch1 with a ch0 commit and an invalid request pending.
    send(1, 40);
    repeat (5) tick();
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'd200;
    cfg_valid3 = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_valid3 = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_reset("midrst");
    #30;
    @(negedge refclk);
    rst_n = 1'b1;
    model_reset();
    repeat (60) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
